// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserialiser with configurable width, bit order and parity,
// holding each received word under a valid/ack handshake with error and overrun flags.
module uart_rx_deser #(
    parameter int DATA_W     = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              RX_in,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;
    logic              acc;
    logic              mis;
    assign sr_next = LSB_FIRST ? {RX_in, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], RX_in};
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            acc         <= 1'b0;
            mis         <= 1'b0;
            RX_DATA     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (rx_ack && rx_valid) begin
                rx_valid    <= 1'b0;
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (shift) begin
                case (state)
                    IDLE: if (!RX_in) begin
                        state <= DATA;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        acc   <= 1'b0;
                        mis   <= 1'b0;
                    end
                    DATA: begin
                        sr  <= sr_next;
                        acc <= acc ^ RX_in;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(DATA_W - 1)) state <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        mis   <= acc ^ RX_in ^ PARITY_ODD;
                        state <= STOP;
                    end
                    default: begin
                        RX_DATA     <= sr;
                        rx_valid    <= 1'b1;
                        frame_err   <= ~RX_in;
                        parity_err  <= PARITY_EN & mis;
                        // A same-cycle ack consumes the old word, so only an unacked held word overruns
                        overrun_err <= !rx_ack && (overrun_err || rx_valid);
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: scoreboard bench over three configurations (8N1 LSB-first, 8-bit MSB-first odd parity, 5-bit LSB-first).
module tb_uart_rx_deser;
    typedef struct {
        int          k;
        logic [15:0] d;
        logic [3:0]  f;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       shift = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_ack = 1'b0;
    logic [2:0] sel = 3'b001;
    logic [2:0] sh, rx, ak;
    logic [2:0] valid, pe, fe, ov, busy;
    logic [2:0] pbusy = 3'b000;
    logic [7:0] d8, dm;
    logic [4:0] d5;
    logic [15:0] dout [3];
    logic [3:0]  flg  [3];
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign sh = {3{shift}} & sel;
    assign rx = ~sel | {3{rx_line}};
    assign ak = {3{rx_ack}} & sel;
    assign dout[0] = {8'h00, d8};
    assign dout[1] = {8'h00, dm};
    assign dout[2] = {11'h000, d5};
    assign flg[0] = {valid[0], pe[0], fe[0], ov[0]};
    assign flg[1] = {valid[1], pe[1], fe[1], ov[1]};
    assign flg[2] = {valid[2], pe[2], fe[2], ov[2]};

    uart_rx_deser #(.DATA_W(8)) u8 (
        .clk(clk), .reset(reset), .shift(sh[0]), .RX_in(rx[0]), .rx_ack(ak[0]),
        .RX_DATA(d8), .rx_valid(valid[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun_err(ov[0]), .busy(busy[0])
    );
    uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) um (
        .clk(clk), .reset(reset), .shift(sh[1]), .RX_in(rx[1]), .rx_ack(ak[1]),
        .RX_DATA(dm), .rx_valid(valid[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun_err(ov[1]), .busy(busy[1])
    );
    uart_rx_deser #(.DATA_W(5)) u5 (
        .clk(clk), .reset(reset), .shift(sh[2]), .RX_in(rx[2]), .rx_ack(ak[2]),
        .RX_DATA(d5), .rx_valid(valid[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .overrun_err(ov[2]), .busy(busy[2])
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // A completed frame is recognised by busy falling outside reset
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset && pbusy[k] && !busy[k]) begin
                if (q.size() == 0) begin
                    chk($sformatf("unexpected_word_dut%0d", k), dout[k], 16'hxxxx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_dut", 16'(k), 16'(e.k));
                    chk($sformatf("rx_data_dut%0d", k), dout[k], e.d);
                    chk($sformatf("flags_vpfo_dut%0d", k), {12'h000, flg[k]}, {12'h000, e.f});
                end
            end
        end
        pbusy = busy;
    end

    task automatic strobe(input logic b, input logic ack, input int gap);
        rx_line = b;
        rx_ack  = ack;
        shift   = 1'b1;
        @(posedge clk); #1;
        shift  = 1'b0;
        rx_ack = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int k, input logic [15:0] d, input int w, input bit lsb, input int pen,
                         input bit par, input bit stop, input int gap, input bit ack_last, input logic [3:0] f);
        exp_t e;
        e.k = k; e.d = d; e.f = f;
        q.push_back(e);
        sel = 3'(1 << k);
        strobe(1'b0, 1'b0, gap);
        for (int i = 0; i < w; i++) strobe(lsb ? d[i] : d[w-1-i], 1'b0, gap);
        if (pen != 0) strobe(par, 1'b0, gap);
        strobe(stop, ack_last, gap);
    endtask

    task automatic ack(input int k);
        sel = 3'(1 << k);
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("after_ack_flags_dut%0d", k), {12'h000, flg[k]}, 16'h0000);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_data_dut%0d", k), dout[k], 16'h0000);
            chk($sformatf("reset_flags_dut%0d", k), {11'h000, flg[k], busy[k]}, 16'h0000);
        end
        @(posedge clk); #1;
        frame(0, 16'hA5, 8, 1, 0, 0, 1, 1, 0, 4'b1000);
        ack(0);
        frame(1, 16'hA5, 8, 0, 1, 1, 1, 1, 0, 4'b1000);
        ack(1);
        frame(1, 16'hA5, 8, 0, 1, 0, 1, 1, 0, 4'b1100);
        ack(1);
        frame(0, 16'h3C, 8, 1, 0, 0, 0, 1, 0, 4'b1010);
        ack(0);
        frame(0, 16'h11, 8, 1, 0, 0, 1, 0, 0, 4'b1000);
        frame(0, 16'h22, 8, 1, 0, 0, 1, 0, 0, 4'b1001);
        ack(0);
        frame(0, 16'h11, 8, 1, 0, 0, 1, 0, 0, 4'b1000);
        frame(0, 16'h22, 8, 1, 0, 0, 1, 0, 1, 4'b1000);
        ack(0);
        frame(0, 16'h11, 8, 1, 0, 0, 1, 1, 0, 4'b1000);
        strobe(1'b0, 1'b0, 1);
        strobe(1'b1, 1'b0, 1);
        strobe(1'b0, 1'b0, 1);
        strobe(1'b1, 1'b0, 1);
        strobe(1'b1, 1'b0, 1);
        chk("mid_frame_busy", {15'h0000, busy[0]}, 16'h0001);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset_data", dout[0], 16'h0000);
        chk("midreset_flags", {11'h000, flg[0], busy[0]}, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(1'b1, 1'b0, 1);
            chk("idle_strobe_busy", {15'h0000, busy[0]}, 16'h0000);
        end
        frame(0, 16'h5A, 8, 1, 0, 0, 1, 1, 0, 4'b1000);
        ack(0);
        frame(2, 16'h13, 5, 1, 0, 0, 1, 2, 0, 4'b1000);
        ack(2);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 16'(q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Parametrised UART receive deserialiser, the successor to the fixed 8-bit shift-in register in the UART receive path. It frames a serial bit stream sampled on an external mid-bit strobe (`shift`), detects the start bit and counts data bits internally. It supports configurable width, bit order and optional parity, checks the stop bit, and holds the received word for a consumer under a valid/ack handshake with overrun detection.

## Interface
- `DATA_W`, default 8: data bits per frame, 5..16.
- `LSB_FIRST`, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit DATA_W-1.
- `PARITY_EN`, default 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset (sampled on the rising edge of clk).
- `shift`  in  1: one-cycle sample strobe at mid-bit, from the baud generator.
- `RX_in`  in  1: serial line, already synchronised; idle high.
- `rx_ack`  in  1: consumer has taken `RX_DATA`; clears `rx_valid` and the error flags.
- `RX_DATA`  out  DATA_W: last completed word, held until the next completion.
- `rx_valid`  out  1: a word is waiting; level signal.
- `parity_err`  out  1: parity mismatch on the held word.
- `frame_err`  out  1: stop bit sampled low on the held word.
- `overrun_err`  out  1: a word completed while `rx_valid` was already 1; sticky until `rx_ack`.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- Every output resets to 0 and the FSM resets to IDLE. `reset` has priority over all other inputs, including mid-frame.
- All FSM actions below happen only on cycles where `shift=1`. With `shift=0` the state, counter and shift register hold.
- **IDLE**
  - Sample `RX_in`=0: go to DATA, bit counter = 0, clear parity accumulator.
  - Sample `RX_in`=1: stay in IDLE.
- **DATA**
  - Shift `RX_in` into the internal shift register and XOR it into the parity accumulator.
  - LSB_FIRST=1: shift right, new bit into [DATA_W-1]. LSB_FIRST=0: shift left, new bit into [0].
  - After the DATA_W-th bit: go to PARITY if PARITY_EN=1, else STOP.
- **PARITY**
  - Sample `RX_in`; mismatch flag = accumulator ^ `RX_in` ^ PARITY_ODD.
  - Go to STOP.
- **STOP**
  - Sample the stop bit.
  - Copy the shift register to `RX_DATA` and set `rx_valid`=1.
  - `frame_err` = ~`RX_in`. `parity_err` = mismatch flag (always 0 if PARITY_EN=0).
  - Set `overrun_err` if `rx_valid` was already 1 and `rx_ack`=0 this cycle.
  - Go to IDLE. A frame with a low stop bit is still delivered, with `frame_err` set.
- **Consumer side**
  - `rx_ack`=1 with no completion in the same cycle: clears `rx_valid`, `parity_err`, `frame_err` and `overrun_err`.
  - `rx_ack`=1 in the same cycle as a completion: the ack consumes the old word, the new word loads, `rx_valid` stays 1, and `overrun_err` is not set.
  - `rx_ack` while `rx_valid`=0: no effect.
- An overrun overwrites `RX_DATA` with the newer word.
- Bit counter width: clog2(DATA_W+1). The counter never wraps within a frame.
- No false-start rejection: a start bit is accepted on a single low sample.

## Timing
- The start bit is qualified on the `shift` cycle that samples it; `busy` rises on the next clk.
- Latency: `RX_DATA`, `rx_valid` and the error flags update on the clk edge that samples the stop bit, and are visible the following cycle.
- A frame takes 1 + DATA_W + PARITY_EN + 1 `shift` strobes.
- `busy` falls together with the `rx_valid` rise.
- A start bit can be accepted on the `shift` strobe immediately after the stop strobe (back-to-back frames).
- `rx_ack` takes effect on the next edge: `rx_valid` is low the cycle after ack.

## Test plan
- **LSB-first 8N1:** DATA_W=8, LSB_FIRST=1, PARITY_EN=0. Send start 0, bits 1,0,1,0,0,1,0,1, stop 1 → `RX_DATA`=0xA5, `rx_valid`=1, no errors, `busy` low. Pulse `rx_ack` → `rx_valid`=0.
- **MSB-first, odd parity:** LSB_FIRST=0, PARITY_EN=1, PARITY_ODD=1. Send 0xA5 MSB-first with parity 1 → `RX_DATA`=0xA5, `parity_err`=0. Resend with parity 0 → `parity_err`=1 and the word is still delivered.
- **Framing error:** 8N1, data 0x3C, stop bit 0 → `RX_DATA`=0x3C, `frame_err`=1. `rx_ack` clears both `frame_err` and `rx_valid`.
- **Overrun:** receive 0x11 without ack, then 0x22 back-to-back → `RX_DATA`=0x22, `overrun_err`=1. Repeat with `rx_ack` on the completion cycle of 0x22 → `overrun_err`=0, `rx_valid`=1.
- **Reset mid-frame and idle strobes:** assert `reset` low after 4 data bits → all outputs 0, IDLE. Then strobe `shift` with `RX_in`=1 ten times → `busy` stays 0. Then a clean 0x5A frame → 0x5A received.
- **Width and gating:** DATA_W=5, insert idle cycles (`shift`=0) between strobes, send 0x13 LSB-first → `RX_DATA`=5'h13. No state change occurs on non-strobe cycles.
